// File: rtl/dut_port_arbiter_pkg.sv
// Shared types and default widths for the dut port arbiter.
package dut_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_TO_W    = 5;

endpackage

// File: rtl/dut_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The priority holder wins a tie; on advance
// the priority passes to the requester that was not granted.
module rr_arb2
  import dut_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid_a,
  input  logic valid_b,
  input  logic advance,
  output logic grant_a,
  output logic grant_b
);

  owner_t prio_q;

  // Grant the priority holder if it asks, otherwise whoever is asking.
  always_comb begin
    grant_a = valid_a && ((prio_q == OWNER_A) || !valid_b);
    grant_b = valid_b && !grant_a;
  end

  // Priority flop: after each accepted grant the other side goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= OWNER_A;
    end else if (advance) begin
      prio_q <= grant_a ? OWNER_B : OWNER_A;
    end
  end

endmodule

// File: rtl/dut_port_arbiter.sv
// Shares the dut register port between requesters A and B, one transaction
// at a time, with a bounded wait for the dut rdy strobes.
//
// Handshake: a command transfers on a cycle where req_x_valid && req_x_ready
// are both high; ready depends only on state, arbitration and RST, never on
// the command fields. Responses are a one-cycle rsp_x_valid pulse with no
// back-pressure.
module dut_port_arbiter
  import dut_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = DEF_TO_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_a_valid,
  output logic              req_a_ready,
  input  logic              req_a_we,
  input  logic [ADDR_W-1:0] req_a_addr,
  input  logic [DATA_W-1:0] req_a_wdata,
  output logic              rsp_a_valid,
  output logic [DATA_W-1:0] rsp_a_data,
  output logic              rsp_a_err,
  input  logic              req_b_valid,
  output logic              req_b_ready,
  input  logic              req_b_we,
  input  logic [ADDR_W-1:0] req_b_addr,
  input  logic [DATA_W-1:0] req_b_wdata,
  output logic              rsp_b_valid,
  output logic [DATA_W-1:0] rsp_b_data,
  output logic              rsp_b_err,
  output logic [ADDR_W-1:0] dut_write_address,
  output logic [DATA_W-1:0] dut_write_data,
  output logic              dut_write_en,
  input  logic              dut_write_rdy,
  output logic [ADDR_W-1:0] dut_read_address,
  output logic              dut_read_en,
  input  logic              dut_read_rdy,
  input  logic [DATA_W-1:0] dut_read_data,
  output logic              busy,
  output state_t            dbg_state
);

  // Last counter value before the abort; only meaningful when TIMEOUT != 0.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t            state;
  owner_t            owner;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [TO_W-1:0]   to_cnt;
  logic              grant_a;
  logic              grant_b;
  logic              accept;
  logic              fire;
  logic              timeout_hit;
  logic [DATA_W-1:0] rsp_data_nxt;

  rr_arb2 u_arb (
    .clk     (CLK),
    .rst     (RST),
    .valid_a (req_a_valid),
    .valid_b (req_b_valid),
    .advance (accept),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  // Handshake, dut enables and abort detection.
  always_comb begin
    req_a_ready  = (state == ST_IDLE) && grant_a && !RST;
    req_b_ready  = (state == ST_IDLE) && grant_b && !RST;
    accept       = req_a_ready || req_b_ready;
    dut_write_en = (state == ST_ISSUE) && cmd_we && dut_write_rdy && !RST;
    dut_read_en  = (state == ST_ISSUE) && !cmd_we && dut_read_rdy && !RST;
    fire         = dut_write_en || dut_read_en;
    timeout_hit  = (TIMEOUT != 0) && (state == ST_ISSUE) && !fire && (to_cnt == TO_LAST);
    rsp_data_nxt = dut_read_en ? dut_read_data : '0;
  end

  assign dut_write_address = cmd_addr;
  assign dut_read_address  = cmd_addr;
  assign dut_write_data    = cmd_wdata;
  assign busy              = (state != ST_IDLE);
  assign dbg_state         = state;

  // Transaction FSM with command latch, stall counter and response registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      owner       <= OWNER_A;
      cmd_we      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      to_cnt      <= '0;
      rsp_a_valid <= 1'b0;
      rsp_a_data  <= '0;
      rsp_a_err   <= 1'b0;
      rsp_b_valid <= 1'b0;
      rsp_b_data  <= '0;
      rsp_b_err   <= 1'b0;
    end else begin
      rsp_a_valid <= 1'b0;
      rsp_a_data  <= '0;
      rsp_a_err   <= 1'b0;
      rsp_b_valid <= 1'b0;
      rsp_b_data  <= '0;
      rsp_b_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner     <= req_b_ready ? OWNER_B : OWNER_A;
            cmd_we    <= req_b_ready ? req_b_we : req_a_we;
            cmd_addr  <= req_b_ready ? req_b_addr : req_a_addr;
            cmd_wdata <= req_b_ready ? req_b_wdata : req_a_wdata;
            to_cnt    <= '0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (fire || timeout_hit) begin
            state <= ST_RESP;
            if (owner == OWNER_A) begin
              rsp_a_valid <= 1'b1;
              rsp_a_data  <= rsp_data_nxt;
              rsp_a_err   <= timeout_hit;
            end else begin
              rsp_b_valid <= 1'b1;
              rsp_b_data  <= rsp_data_nxt;
              rsp_b_err   <= timeout_hit;
            end
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dut_port_arbiter.sv
// Directed and randomized transactions against a transaction-level model of
// the arbiter: grant from a priority bit, ISSUE length from the stall count.
module tb_dut_port_arbiter;

  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 5;

  logic              CLK;
  logic              RST;
  logic              req_a_valid, req_a_ready, req_a_we;
  logic [ADDR_W-1:0] req_a_addr;
  logic [DATA_W-1:0] req_a_wdata;
  logic              rsp_a_valid, rsp_a_err;
  logic [DATA_W-1:0] rsp_a_data;
  logic              req_b_valid, req_b_ready, req_b_we;
  logic [ADDR_W-1:0] req_b_addr;
  logic [DATA_W-1:0] req_b_wdata;
  logic              rsp_b_valid, rsp_b_err;
  logic [DATA_W-1:0] rsp_b_data;
  logic [ADDR_W-1:0] dut_write_address, dut_read_address;
  logic [DATA_W-1:0] dut_write_data, dut_read_data;
  logic              dut_write_en, dut_write_rdy, dut_read_en, dut_read_rdy;
  logic              busy;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;
  bit m_prio_b = 1'b0;

  dut_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) u_dut (
    .CLK               (CLK),
    .RST               (RST),
    .req_a_valid       (req_a_valid),
    .req_a_ready       (req_a_ready),
    .req_a_we          (req_a_we),
    .req_a_addr        (req_a_addr),
    .req_a_wdata       (req_a_wdata),
    .rsp_a_valid       (rsp_a_valid),
    .rsp_a_data        (rsp_a_data),
    .rsp_a_err         (rsp_a_err),
    .req_b_valid       (req_b_valid),
    .req_b_ready       (req_b_ready),
    .req_b_we          (req_b_we),
    .req_b_addr        (req_b_addr),
    .req_b_wdata       (req_b_wdata),
    .rsp_b_valid       (rsp_b_valid),
    .rsp_b_data        (rsp_b_data),
    .rsp_b_err         (rsp_b_err),
    .dut_write_address (dut_write_address),
    .dut_write_data    (dut_write_data),
    .dut_write_en      (dut_write_en),
    .dut_write_rdy     (dut_write_rdy),
    .dut_read_address  (dut_read_address),
    .dut_read_en       (dut_read_en),
    .dut_read_rdy      (dut_read_rdy),
    .dut_read_data     (dut_read_data),
    .busy              (busy),
    .dbg_state         (dbg_state)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One transaction from IDLE through RESP. stalls = ISSUE cycles with rdy low
  // before the firing cycle; stalls >= TIMEOUT means the dut never answers.
  task automatic run_txn(input bit av, input bit bv, input int stalls, input logic [7:0] rd);
    bit gb, we, to, fire_now;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] wd;
    int n_issue;
    req_a_valid = av;
    req_b_valid = bv;
    dut_write_rdy = 1'b0;
    dut_read_rdy  = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    if (!av && !bv) begin
      chk("idle_rdy_a", req_a_ready, 0);
      chk("idle_rdy_b", req_b_ready, 0);
      step();
      return;
    end
    gb = (m_prio_b && bv) || !av;
    chk("grant_a", req_a_ready, !gb);
    chk("grant_b", req_b_ready, gb);
    we = gb ? req_b_we : req_a_we;
    ad = gb ? req_b_addr : req_a_addr;
    wd = gb ? req_b_wdata : req_a_wdata;
    m_prio_b = !gb;
    step();
    to = (TIMEOUT != 0) && (stalls >= TIMEOUT);
    n_issue = to ? TIMEOUT : stalls + 1;
    for (int s = 0; s < n_issue; s++) begin
      fire_now = !to && (s == stalls);
      if (we) begin
        dut_write_rdy = fire_now;
        dut_read_rdy  = 1'($urandom_range(0, 1));
      end else begin
        dut_read_rdy  = fire_now;
        dut_write_rdy = 1'($urandom_range(0, 1));
      end
      dut_read_data = fire_now ? rd : 8'($urandom);
      #1;
      chk("iss_wen", dut_write_en, we && fire_now);
      chk("iss_ren", dut_read_en, !we && fire_now);
      if (we) begin
        chk("iss_waddr", dut_write_address, ad);
        chk("iss_wdata", dut_write_data, wd);
      end else begin
        chk("iss_raddr", dut_read_address, ad);
      end
      chk("iss_busy", busy, 1);
      chk("iss_rdy", {req_a_ready, req_b_ready}, 0);
      chk("iss_rsp", {rsp_a_valid, rsp_b_valid}, 0);
      step();
    end
    dut_write_rdy = 1'b0;
    dut_read_rdy  = 1'b0;
    #1;
    chk("rsp_a_valid", rsp_a_valid, !gb);
    chk("rsp_b_valid", rsp_b_valid, gb);
    chk("rsp_data", gb ? rsp_b_data : rsp_a_data, (to || we) ? 8'h00 : rd);
    chk("rsp_err", gb ? rsp_b_err : rsp_a_err, to);
    chk("rsp_other", gb ? {rsp_a_data, rsp_a_err} : {rsp_b_data, rsp_b_err}, 0);
    chk("rsp_en", {dut_write_en, dut_read_en}, 0);
    chk("rsp_busy", busy, 1);
    chk("rsp_rdy", {req_a_ready, req_b_ready}, 0);
    step();
  endtask

  initial begin
    RST = 1'b1;
    req_a_valid = 0; req_a_we = 0; req_a_addr = '0; req_a_wdata = '0;
    req_b_valid = 0; req_b_we = 0; req_b_addr = '0; req_b_wdata = '0;
    dut_write_rdy = 0; dut_read_rdy = 0; dut_read_data = '0;
    step();
    step();
    // reset state, ready gated while RST is high
    req_a_valid = 1'b1;
    #1;
    chk("rst_ready_a", req_a_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_en", {dut_write_en, dut_read_en}, 0);
    chk("rst_addr", {dut_write_address, dut_read_address, dut_write_data}, 0);
    chk("rst_rsp", {rsp_a_valid, rsp_a_data, rsp_a_err, rsp_b_valid, rsp_b_data, rsp_b_err}, 0);
    req_a_valid = 1'b0;
    RST = 1'b0;
    step();

    // A write, no stall
    req_a_we = 1; req_a_addr = 3'd0; req_a_wdata = 8'h5A;
    run_txn(1, 0, 0, 8'h00);

    // B read, 4 stall cycles
    req_b_we = 0; req_b_addr = 3'd3;
    run_txn(0, 1, 4, 8'h3C);

    // both valid every cycle: alternate A,B,A,B
    for (int i = 0; i < 4; i++) begin
      req_a_we = 1'($urandom_range(0, 1)); req_a_addr = 3'($urandom); req_a_wdata = 8'($urandom);
      req_b_we = 1'($urandom_range(0, 1)); req_b_addr = 3'($urandom); req_b_wdata = 8'($urandom);
      run_txn(1, 1, 0, 8'($urandom));
    end

    // timeout on a write with write_rdy held low
    req_a_we = 1; req_a_addr = 3'd6; req_a_wdata = 8'hC3;
    run_txn(1, 0, 20, 8'h00);

    // reset in the middle of ISSUE with rdy high
    req_a_we = 1; req_a_addr = 3'd5; req_a_wdata = 8'hA5;
    req_a_valid = 1; req_b_valid = 0;
    #1;
    chk("mid_accept", req_a_ready, 1);
    step();
    req_a_valid = 0;
    dut_write_rdy = 1;
    RST = 1;
    #1;
    chk("mid_rst_wen", dut_write_en, 0);
    step();
    RST = 0;
    dut_write_rdy = 0;
    m_prio_b = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_rsp", {rsp_a_valid, rsp_b_valid, rsp_a_data, rsp_b_data}, 0);
    chk("mid_outs", {dut_write_address, dut_write_data, dut_write_en, dut_read_en}, 0);
    run_txn(1, 1, 0, 8'h11);

    // B alone, three reads
    for (int i = 0; i < 3; i++) begin
      req_b_we = 0; req_b_addr = 3'($urandom);
      run_txn(0, 1, $urandom_range(0, 2), 8'($urandom));
    end

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      req_a_we = 1'($urandom_range(0, 1)); req_a_addr = 3'($urandom); req_a_wdata = 8'($urandom);
      req_b_we = 1'($urandom_range(0, 1)); req_b_addr = 3'($urandom); req_b_wdata = 8'($urandom);
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 17 : $urandom_range(0, 3), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
